// File: rtl/ext_led_pkg.sv
// Shared constants and helpers for the external LED PWM GPIO block:
// register offsets, prescaler width and the byte-lane merge used by every register.
package ext_led_pkg;

    localparam logic [7:0] OFF_DATA     = 8'h00;
    localparam logic [7:0] OFF_MODE     = 8'h04;
    localparam logic [7:0] OFF_PRESCALE = 8'h08;
    localparam logic [7:0] OFF_DUTY0    = 8'h10;

    localparam int unsigned PRESC_W = 16;

    typedef logic [PRESC_W-1:0] presc_t;

    // Replace the bytes of old_val selected by be with the matching bytes of new_val.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] result;
        result = old_val;
        for (int unsigned b = 0; b < 4; b++) begin
            if (be[b]) begin
                result[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return result;
    endfunction

    function automatic logic [7:0] duty_off(input int unsigned idx);
        return OFF_DUTY0 + 8'(idx << 2);
    endfunction

endpackage

// File: rtl/led_pwm_timebase.sv
// Shared PWM timebase: a prescaler producing tick and a free-running PWM counter
// that advances once per tick.
module led_pwm_timebase
    import ext_led_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  presc_t              prescale,
    output logic                tick,
    output logic [PWM_BITS-1:0] pwm_cnt
);

    presc_t              presc_cnt_q, presc_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;

    // >= rather than == so that lowering PRESCALE below the running count ticks at once.
    assign tick = (presc_cnt_q >= prescale);

    always_comb begin
        presc_cnt_d = tick ? '0 : presc_cnt_q + presc_t'(1);
        pwm_cnt_d   = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt_q <= '0;
            pwm_cnt_q   <= '0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
        end
    end

    assign pwm_cnt = pwm_cnt_q;

endmodule

// File: rtl/ext_led_pwm_gpio.sv
// Memory-mapped LED controller: per-channel static or PWM drive on a byte-lane bus.
// Define EXT_LED_ACTIVE_LOW_EN for inverted (active-low) LED drive.
module ext_led_pwm_gpio
    import ext_led_pkg::*;
#(
    parameter int unsigned NUM_LEDS  = 5,
    parameter int unsigned PWM_BITS  = 8,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         addr,
    input  logic [31:0]         data_in,
    input  logic                rd_strobe,
    input  logic [3:0]          wr_strobe,
    output logic [31:0]         data_out,
    output logic [NUM_LEDS-1:0] leds
);

    logic       sel;
    logic [7:0] off;

    logic [NUM_LEDS-1:0] data_q, data_d;
    logic [NUM_LEDS-1:0] mode_q, mode_d;
    presc_t              prescale_q, prescale_d;
    logic [PWM_BITS-1:0] duty_q [NUM_LEDS];
    logic [PWM_BITS-1:0] duty_d [NUM_LEDS];
    logic [31:0]         rdata;
    logic [31:0]         data_out_q, data_out_d;
    logic [NUM_LEDS-1:0] on;
    logic [NUM_LEDS-1:0] leds_q, leds_d;

    logic                tick;
    logic [PWM_BITS-1:0] pwm_cnt;

    assign sel = (addr[31:8] == BASE_ADDR[31:8]);
    assign off = addr[7:0];

    led_pwm_timebase #(
        .PWM_BITS (PWM_BITS)
    ) u_timebase (
        .clk      (clk),
        .rst      (rst),
        .prescale (prescale_q),
        .tick     (tick),
        .pwm_cnt  (pwm_cnt)
    );

    // An all-zero wr_strobe merges nothing, so no separate write-enable is needed.
    always_comb begin
        data_d     = data_q;
        mode_d     = mode_q;
        prescale_d = prescale_q;
        if (sel && off == OFF_DATA) begin
            data_d = NUM_LEDS'(byte_merge(32'(data_q), data_in, wr_strobe));
        end
        if (sel && off == OFF_MODE) begin
            mode_d = NUM_LEDS'(byte_merge(32'(mode_q), data_in, wr_strobe));
        end
        if (sel && off == OFF_PRESCALE) begin
            prescale_d = presc_t'(byte_merge(32'(prescale_q), data_in, wr_strobe));
        end
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            duty_d[i] = duty_q[i];
            if (sel && off == duty_off(i)) begin
                duty_d[i] = PWM_BITS'(byte_merge(32'(duty_q[i]), data_in, wr_strobe));
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (off == OFF_DATA) begin
            rdata = 32'(data_q);
        end else if (off == OFF_MODE) begin
            rdata = 32'(mode_q);
        end else if (off == OFF_PRESCALE) begin
            rdata = 32'(prescale_q);
        end
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            if (off == duty_off(i)) begin
                rdata = 32'(duty_q[i]);
            end
        end
        // Read samples the pre-write register value, so a same-cycle write is not lost.
        data_out_d = (rd_strobe && sel) ? rdata : data_out_q;
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            on[i] = data_q[i] & (mode_q[i] ? (pwm_cnt < duty_q[i]) : 1'b1);
        end
        leds_d = on;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q     <= '0;
            mode_q     <= '0;
            prescale_q <= '0;
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                duty_q[i] <= '0;
            end
            data_out_q <= '0;
            leds_q     <= '0;
        end else begin
            data_q     <= data_d;
            mode_q     <= mode_d;
            prescale_q <= prescale_d;
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                duty_q[i] <= duty_d[i];
            end
            data_out_q <= data_out_d;
            leds_q     <= leds_d;
        end
    end

    assign data_out = data_out_q;

`ifdef EXT_LED_ACTIVE_LOW_EN
    assign leds = ~leds_q;
`else
    assign leds = leds_q;
`endif

endmodule

// File: tb/tb_ext_led_pwm_gpio.sv
// Directed self-checking bench for ext_led_pwm_gpio (default parameters).
module tb_ext_led_pwm_gpio;

    localparam logic [31:0] BASE = 32'h8000_0000;
`ifdef EXT_LED_ACTIVE_LOW_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic        rd_strobe;
    logic [3:0]  wr_strobe;
    logic [31:0] data_out;
    logic [4:0]  leds;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ext_led_pwm_gpio dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .data_in   (data_in),
        .rd_strobe (rd_strobe),
        .wr_strobe (wr_strobe),
        .data_out  (data_out),
        .leds      (leds)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_leds(input logic [4:0] v);
        return 32'(v ^ {5{INV}});
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        addr      = a;
        data_in   = d;
        wr_strobe = be;
        @(negedge clk);
        wr_strobe = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr      = a;
        rd_strobe = 1'b1;
        @(negedge clk);
        rd_strobe = 1'b0;
        d         = data_out;
    endtask

    task automatic count_on(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (leds[0] ^ INV) cnt++;
        end
    endtask

    logic [31:0] rd;
    int          cnt;
    int          found;

    initial begin
        rst       = 1'b1;
        addr      = '0;
        data_in   = '0;
        rd_strobe = 1'b0;
        wr_strobe = 4'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check_eq("rst_data_out", data_out, 32'h0);
        check_eq("rst_leds", 32'(leds), exp_leds(5'b00000));
        bus_read(BASE + 32'h00, rd); check_eq("rst_rd_data", rd, 32'h0);
        bus_read(BASE + 32'h04, rd); check_eq("rst_rd_mode", rd, 32'h0);
        bus_read(BASE + 32'h08, rd); check_eq("rst_rd_presc", rd, 32'h0);
        bus_read(BASE + 32'h10, rd); check_eq("rst_rd_duty0", rd, 32'h0);

        // Static mode
        bus_write(BASE + 32'h00, 32'h0000_0015, 4'b0001);
        @(negedge clk);
        @(negedge clk);
        check_eq("static_leds", 32'(leds), exp_leds(5'b10101));
        bus_read(BASE + 32'h00, rd); check_eq("static_rd_data", rd, 32'h0000_0015);

        // Byte lanes, window decode, unmapped offsets
        bus_write(BASE + 32'h08, 32'h0000_ABCD, 4'b0010);
        bus_read(BASE + 32'h08, rd); check_eq("lane_presc", rd, 32'h0000_AB00);
        bus_read(32'h8000_0100, rd); check_eq("outside_rd_holds", rd, 32'h0000_AB00);
        bus_write(32'h8000_0100, 32'hFFFF_FFFF, 4'hF);
        bus_write(32'h8000_0108, 32'hFFFF_FFFF, 4'hF);
        bus_read(BASE + 32'h00, rd); check_eq("outside_data", rd, 32'h0000_0015);
        bus_read(BASE + 32'h08, rd); check_eq("outside_presc", rd, 32'h0000_AB00);
        bus_write(BASE + 32'h24, 32'hFFFF_FFFF, 4'hF);
        bus_read(BASE + 32'h24, rd); check_eq("unmapped_duty5", rd, 32'h0);
        bus_write(BASE + 32'h0C, 32'hFFFF_FFFF, 4'hF);
        bus_read(BASE + 32'h0C, rd); check_eq("unmapped_0c", rd, 32'h0);

        // PWM duty with PRESCALE=0
        bus_write(BASE + 32'h08, 32'h0, 4'hF);
        bus_write(BASE + 32'h04, 32'h01, 4'hF);
        bus_write(BASE + 32'h00, 32'h01, 4'hF);
        bus_write(BASE + 32'h10, 32'hFFFF_FF40, 4'hF);
        bus_read(BASE + 32'h10, rd); check_eq("duty_trunc", rd, 32'h40);
        count_on(256, cnt); check_eq("duty64", 32'(cnt), 32'd64);
        bus_write(BASE + 32'h10, 32'h00, 4'h1);
        count_on(256, cnt); check_eq("duty0", 32'(cnt), 32'd0);
        bus_write(BASE + 32'h10, 32'hFF, 4'h1);
        count_on(256, cnt); check_eq("duty255", 32'(cnt), 32'd255);

        // Prescaler
        bus_write(BASE + 32'h10, 32'h40, 4'h1);
        bus_write(BASE + 32'h08, 32'h3, 4'b0011);
        count_on(1024, cnt); check_eq("presc3_duty64", 32'(cnt), 32'd256);
        found = 0;
        for (int k = 0; k < 16 && found == 0; k++) begin
            @(negedge clk);
            if (dut.u_timebase.tick) found = 1;
        end
        check_eq("tick_found", 32'(found), 32'd1);
        // Tick seen with count 3; land PRESCALE=1 on the edge that moves count 2 -> 3.
        repeat (2) @(negedge clk);
        bus_write(BASE + 32'h08, 32'h1, 4'b0011);
        check_eq("tick_now", 32'(dut.u_timebase.tick), 32'd1);
        @(negedge clk); check_eq("tick_gap1", 32'(dut.u_timebase.tick), 32'd0);
        @(negedge clk); check_eq("tick_next1", 32'(dut.u_timebase.tick), 32'd1);
        @(negedge clk); check_eq("tick_gap2", 32'(dut.u_timebase.tick), 32'd0);
        @(negedge clk); check_eq("tick_next2", 32'(dut.u_timebase.tick), 32'd1);

        // Simultaneous read and write
        bus_write(BASE + 32'h00, 32'h03, 4'hF);
        @(negedge clk);
        addr      = BASE;
        data_in   = 32'h1C;
        wr_strobe = 4'hF;
        rd_strobe = 1'b1;
        @(negedge clk);
        wr_strobe = 4'h0;
        rd_strobe = 1'b0;
        check_eq("rw_old", data_out, 32'h03);
        bus_read(BASE + 32'h00, rd); check_eq("rw_new", rd, 32'h1C);
        check_eq("rw_leds", 32'(leds), exp_leds(5'b11100));

        // Reset mid-period
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mid_rst_leds", 32'(leds), exp_leds(5'b00000));
        check_eq("mid_rst_dout", data_out, 32'h0);
        check_eq("mid_rst_pwm", 32'(dut.u_timebase.pwm_cnt), 32'h0);
        bus_read(BASE + 32'h04, rd); check_eq("mid_rst_mode", rd, 32'h0);
        check_eq("mid_rst_leds2", 32'(leds), exp_leds(5'b00000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
